// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the skewed weight-stationary systolic array.
package systolic_pkg;

  typedef enum logic [1:0] {
    LOAD_W  = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  function automatic int latency(input int rows, input int cols);
    return rows + cols;
  endfunction

  // Full product width plus enough headroom to sum ROWS products without wrapping.
  function automatic int acc_size_default(input int data_size, input int rows);
    return 2 * data_size + $clog2(rows);
  endfunction

endpackage

// File: rtl/skewed_systolic_array_if.sv
// Weight, activation and result streams of the systolic array, each with valid/ready.
interface skewed_systolic_array_if import systolic_pkg::*; #(
  parameter int ROWS      = 3,
  parameter int COLS      = 3,
  parameter int DATA_SIZE = 32,
  parameter int ACC_SIZE  = acc_size_default(DATA_SIZE, ROWS)
);
  logic                               w_valid;
  logic                               w_ready;
  logic [COLS-1:0][DATA_SIZE-1:0]     w_data;
  logic                               w_reload;
  logic                               a_valid;
  logic                               a_ready;
  logic [ROWS-1:0][DATA_SIZE-1:0]     a_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [COLS-1:0][ACC_SIZE-1:0]      out_sum;
  logic                               busy;

  modport master (
    output w_valid, w_data, w_reload, a_valid, a_data, out_ready,
    input  w_ready, a_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  w_valid, w_data, w_reload, a_valid, a_data, out_ready,
    output w_ready, a_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/systolic_pe.sv
// Weight-stationary MAC cell: activation passes right, partial sum passes down.
module systolic_pe #(
  parameter int DATA_SIZE = 32,
  parameter int ACC_SIZE  = 66,
  parameter int SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_ld_weight,
  input  logic [DATA_SIZE-1:0] i_weight,
  input  logic [DATA_SIZE-1:0] i_data,
  input  logic [ACC_SIZE-1:0]  i_sum,
  output logic [DATA_SIZE-1:0] o_data,
  output logic [ACC_SIZE-1:0]  o_sum
);
  logic [DATA_SIZE-1:0] r_weight;
  logic [DATA_SIZE-1:0] r_data;
  logic [ACC_SIZE-1:0]  r_sum;
  logic [ACC_SIZE-1:0]  w_prod;

  // Operands are widened to the full product width first so the multiply is exact.
  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*DATA_SIZE-1:0] w_full;
      assign w_full = $signed({{DATA_SIZE{i_data[DATA_SIZE-1]}}, i_data}) *
                      $signed({{DATA_SIZE{r_weight[DATA_SIZE-1]}}, r_weight});
      assign w_prod = ACC_SIZE'(w_full);
    end else begin : g_unsigned
      logic [2*DATA_SIZE-1:0] w_full;
      assign w_full = {{DATA_SIZE{1'b0}}, i_data} * {{DATA_SIZE{1'b0}}, r_weight};
      assign w_prod = ACC_SIZE'(w_full);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_weight <= '0;
      r_data   <= '0;
      r_sum    <= '0;
    end else begin
      if (i_ld_weight) r_weight <= i_weight;
      if (i_en) begin
        r_data <= i_data;
        r_sum  <= i_sum + w_prod;
      end
    end
  end

  assign o_data = r_data;
  assign o_sum  = r_sum;
endmodule

// File: rtl/skewed_systolic_array.sv
// ROWS x COLS weight-stationary matrix-vector engine with input skew, output de-skew
// and a load/compute/drain controller; the whole pipeline stalls on output backpressure.
module skewed_systolic_array import systolic_pkg::*; #(
  parameter int ROWS      = 3,
  parameter int COLS      = 3,
  parameter int DATA_SIZE = 32,
  parameter int ACC_SIZE  = acc_size_default(DATA_SIZE, ROWS),
  parameter int SIGNED    = 1
) (
  input logic                    clk,
  input logic                    reset,
  skewed_systolic_array_if.slave io_bus
);
  localparam int LAT = latency(ROWS, COLS);
  localparam int IFW = $clog2(LAT + 1);
  localparam int WCW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t          r_state;
  logic [WCW-1:0]  r_wr_cnt;
  logic [IFW-1:0]  r_inflight;
  logic [LAT-1:0]  r_vld;
  logic            w_en;
  logic            w_accept;
  logic            w_retire;
  logic [ROWS-1:0] w_ld_row;

  logic [DATA_SIZE-1:0] w_pe_data [ROWS][COLS+1];
  logic [ACC_SIZE-1:0]  w_pe_sum  [ROWS+1][COLS];
  logic [DATA_SIZE-1:0] w_unused_data [ROWS];

  assign w_en              = !(r_vld[LAT-1] && !io_bus.out_ready);
  assign w_accept          = io_bus.a_valid && io_bus.a_ready;
  assign w_retire          = io_bus.out_valid && io_bus.out_ready;
  assign io_bus.out_valid  = r_vld[LAT-1];
  assign io_bus.w_ready    = (r_state == LOAD_W);
  assign io_bus.a_ready    = (r_state == COMPUTE) && w_en;
  assign io_bus.busy       = (r_state != COMPUTE) || (r_inflight != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= LOAD_W;
      r_wr_cnt <= '0;
    end else begin
      case (r_state)
        LOAD_W: if (io_bus.w_valid) begin
          if (r_wr_cnt == WCW'(ROWS - 1)) begin
            r_state  <= COMPUTE;
            r_wr_cnt <= '0;
          end else begin
            r_wr_cnt <= r_wr_cnt + WCW'(1);
          end
        end
        COMPUTE: if (io_bus.w_reload) r_state <= DRAIN;
        DRAIN: if (r_inflight == '0) begin
          r_state  <= LOAD_W;
          r_wr_cnt <= '0;
        end
        default: r_state <= LOAD_W;
      endcase
    end
  end

  // The valid pipe mirrors the data path depth so out_valid lines up with out_sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld      <= '0;
      r_inflight <= '0;
    end else begin
      if (w_en) r_vld <= {r_vld[LAT-2:0], w_accept};
      if (w_accept && !w_retire)      r_inflight <= r_inflight + IFW'(1);
      else if (!w_accept && w_retire) r_inflight <= r_inflight - IFW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      // Row gi sees its element gi cycles after row 0, after one capture stage.
      logic [DATA_SIZE-1:0] r_skew [gi+1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k <= gi; k++) r_skew[k] <= '0;
        end else if (w_en) begin
          r_skew[0] <= io_bus.a_data[gi];
          for (int k = 1; k <= gi; k++) r_skew[k] <= r_skew[k-1];
        end
      end

      assign w_pe_data[gi][0] = r_skew[gi];
      assign w_unused_data[gi] = w_pe_data[gi][COLS];
      assign w_ld_row[gi] = (r_state == LOAD_W) && io_bus.w_valid && (r_wr_cnt == WCW'(gi));

      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
        systolic_pe #(
          .DATA_SIZE (DATA_SIZE),
          .ACC_SIZE  (ACC_SIZE),
          .SIGNED    (SIGNED)
        ) u_pe (
          .clk         (clk),
          .rst         (reset),
          .i_en        (w_en),
          .i_ld_weight (w_ld_row[gi]),
          .i_weight    (io_bus.w_data[gj]),
          .i_data      (w_pe_data[gi][gj]),
          .i_sum       (w_pe_sum[gi][gj]),
          .o_data      (w_pe_data[gi][gj+1]),
          .o_sum       (w_pe_sum[gi+1][gj])
        );
      end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_out
      localparam int DEPTH = COLS - 1 - gj;
      assign w_pe_sum[0][gj] = '0;

      if (DEPTH == 0) begin : g_direct
        assign io_bus.out_sum[gj] = w_pe_sum[ROWS][gj];
      end else begin : g_deskew
        logic [ACC_SIZE-1:0] r_dsk [DEPTH];

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int k = 0; k < DEPTH; k++) r_dsk[k] <= '0;
          end else if (w_en) begin
            r_dsk[0] <= w_pe_sum[ROWS][gj];
            for (int k = 1; k < DEPTH; k++) r_dsk[k] <= r_dsk[k-1];
          end
        end

        assign io_bus.out_sum[gj] = r_dsk[DEPTH-1];
      end
    end
  endgenerate
endmodule

// File: tb/tb_skewed_systolic_array.sv
// Directed bench: a 3x3 32-bit signed array plus a 3x3 8-bit/8-bit-accumulator copy for wrap.
module tb_skewed_systolic_array;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  skewed_systolic_array_if #(.ROWS(3), .COLS(3), .DATA_SIZE(32), .ACC_SIZE(66)) bus0 ();
  skewed_systolic_array_if #(.ROWS(3), .COLS(3), .DATA_SIZE(8),  .ACC_SIZE(8))  bus1 ();

  skewed_systolic_array #(
    .ROWS(3), .COLS(3), .DATA_SIZE(32), .ACC_SIZE(66), .SIGNED(1)
  ) u_dut0 (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus0)
  );

  skewed_systolic_array #(
    .ROWS(3), .COLS(3), .DATA_SIZE(8), .ACC_SIZE(8), .SIGNED(1)
  ) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0][31:0] v3(input int x0, input int x1, input int x2);
    v3[0] = 32'(x0);
    v3[1] = 32'(x1);
    v3[2] = 32'(x2);
  endfunction

  function automatic logic [2:0][65:0] e3(input int x0, input int x1, input int x2);
    e3[0] = 66'(x0);
    e3[1] = 66'(x1);
    e3[2] = 66'(x2);
  endfunction

  task automatic load0(input logic [2:0][31:0] r0, input logic [2:0][31:0] r1,
                       input logic [2:0][31:0] r2);
    logic [2:0][31:0] rows [3];
    int t;
    rows[0] = r0;
    rows[1] = r1;
    rows[2] = r2;
    for (int r = 0; r < 3; r++) begin
      bus0.w_valid = 1'b1;
      bus0.w_data  = rows[r];
      t = 0;
      while (!bus0.w_ready && t < 30) begin
        tick();
        t++;
      end
      chk("load_w_ready", bus0.w_ready, 1);
      tick();
    end
    bus0.w_valid = 1'b0;
  endtask

  task automatic send0(input logic [2:0][31:0] a);
    int t;
    bus0.a_valid = 1'b1;
    bus0.a_data  = a;
    t = 0;
    while (!bus0.a_ready && t < 30) begin
      tick();
      t++;
    end
    chk("send_a_ready", bus0.a_ready, 1);
    tick();
    bus0.a_valid = 1'b0;
  endtask

  task automatic wait_out0();
    int t;
    t = 0;
    while (!bus0.out_valid && t < 40) begin
      tick();
      t++;
    end
  endtask

  task automatic chk_sum0(input string tag, input logic [2:0][65:0] e);
    chk({tag, "_valid"}, bus0.out_valid, 1);
    for (int c = 0; c < 3; c++) chk({tag, "_sum"}, bus0.out_sum[c], e[c]);
  endtask

  task automatic expect0(input string tag, input logic [2:0][65:0] e);
    chk_sum0(tag, e);
    tick();
  endtask

  initial begin
    int t;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus0.w_valid = 0; bus0.w_data = '0; bus0.w_reload = 0;
    bus0.a_valid = 0; bus0.a_data = '0; bus0.out_ready = 1;
    bus1.w_valid = 0; bus1.w_data = '0; bus1.w_reload = 0;
    bus1.a_valid = 0; bus1.a_data = '0; bus1.out_ready = 1;

    #12;
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_w_ready",   bus0.w_ready, 1);
    chk("rst_a_ready",   bus0.a_ready, 0);
    chk("rst_busy",      bus0.busy, 1);
    for (int c = 0; c < 3; c++) chk("rst_out_sum", bus0.out_sum[c], 0);
    #1 reset = 1'b0;
    tick();

    // Signed wrap on the narrow copy: 3 * (-128 * -1) = 384 -> 0x80 mod 256.
    for (int r = 0; r < 3; r++) begin
      bus1.w_valid = 1'b1;
      bus1.w_data  = {3{8'h80}};
      chk("wrap_w_ready", bus1.w_ready, 1);
      tick();
    end
    bus1.w_valid = 1'b0;
    bus1.a_valid = 1'b1;
    bus1.a_data  = {3{8'hFF}};
    chk("wrap_a_ready", bus1.a_ready, 1);
    tick();
    bus1.a_valid = 1'b0;
    t = 0;
    while (!bus1.out_valid && t < 40) begin
      tick();
      t++;
    end
    chk("wrap_valid", bus1.out_valid, 1);
    for (int c = 0; c < 3; c++) chk("wrap_sum", bus1.out_sum[c], 8'h80);
    tick();

    // Identity weights, latency measured in edges from the handshake edge.
    load0(v3(1, 0, 0), v3(0, 1, 0), v3(0, 0, 1));
    chk("id_busy_idle", bus0.busy, 0);
    bus0.a_valid = 1'b1;
    bus0.a_data  = v3(1, 2, 3);
    chk("id_a_ready", bus0.a_ready, 1);
    t = 0;
    do begin
      tick();
      bus0.a_valid = 1'b0;
      t++;
      if (t == 2) chk("id_busy_flight", bus0.busy, 1);
    end while (!bus0.out_valid && t < 30);
    chk("id_latency", t, 6);
    expect0("id", e3(1, 2, 3));
    chk("id_valid_drop", bus0.out_valid, 0);
    chk("id_busy_after", bus0.busy, 0);

    // Full matrix, back-to-back vectors give consecutive results.
    bus0.w_reload = 1'b1;
    tick();
    bus0.w_reload = 1'b0;
    load0(v3(1, 2, 3), v3(4, 5, 6), v3(7, 8, 9));
    send0(v3(1, 0, 0));
    send0(v3(0, 1, 0));
    send0(v3(1, 1, 1));
    wait_out0();
    expect0("b2b0", e3(1, 2, 3));
    expect0("b2b1", e3(4, 5, 6));
    expect0("b2b2", e3(12, 15, 18));
    chk("b2b_end", bus0.out_valid, 0);

    // Backpressure: five stalled cycles with four vectors in the pipe.
    bus0.out_ready = 1'b0;
    send0(v3(1, 0, 0));
    send0(v3(0, 1, 0));
    send0(v3(0, 0, 1));
    send0(v3(2, 1, 0));
    wait_out0();
    chk("bp_a_ready", bus0.a_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_sum0("bp_hold", e3(1, 2, 3));
    end
    bus0.out_ready = 1'b1;
    expect0("bp0", e3(1, 2, 3));
    expect0("bp1", e3(4, 5, 6));
    expect0("bp2", e3(7, 8, 9));
    expect0("bp3", e3(6, 9, 12));
    chk("bp_end", bus0.out_valid, 0);

    // Reload coinciding with the second accepted vector; junk offered during drain.
    send0(v3(1, 1, 1));
    bus0.a_valid  = 1'b1;
    bus0.a_data   = v3(0, 0, 1);
    bus0.w_reload = 1'b1;
    chk("rl_a_ready", bus0.a_ready, 1);
    tick();
    bus0.w_reload = 1'b0;
    bus0.a_data   = v3(5, 5, 5);
    chk("rl_drain_a_ready", bus0.a_ready, 0);
    chk("rl_drain_w_ready", bus0.w_ready, 0);
    chk("rl_drain_busy",    bus0.busy, 1);
    wait_out0();
    expect0("rl0", e3(12, 15, 18));
    expect0("rl1", e3(7, 8, 9));
    chk("rl_no_extra", bus0.out_valid, 0);
    bus0.a_valid = 1'b0;
    t = 0;
    while (!bus0.w_ready && t < 20) begin
      tick();
      t++;
    end
    chk("rl_w_ready", bus0.w_ready, 1);
    load0(v3(2, 0, 0), v3(0, 2, 0), v3(0, 0, 2));
    send0(v3(1, 1, 1));
    wait_out0();
    expect0("rl_new", e3(2, 2, 2));

    // Signed operands at full width.
    send0(v3(-1, 2, -3));
    wait_out0();
    expect0("signed", e3(-2, 4, -6));

    // Asynchronous reset in the middle of a stalled stream.
    bus0.out_ready = 1'b0;
    send0(v3(1, 2, 3));
    send0(v3(4, 5, 6));
    wait_out0();
    chk("ar_pre_valid", bus0.out_valid, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar_out_valid", bus0.out_valid, 0);
    chk("ar_w_ready",   bus0.w_ready, 1);
    chk("ar_a_ready",   bus0.a_ready, 0);
    for (int c = 0; c < 3; c++) chk("ar_out_sum", bus0.out_sum[c], 0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus0.out_ready = 1'b1;

    // Reset again mid-load: the next load must start over at row 0.
    bus0.w_valid = 1'b1;
    bus0.w_data  = v3(9, 9, 9);
    tick();
    bus0.w_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    load0(v3(1, 2, 3), v3(4, 5, 6), v3(7, 8, 9));
    send0(v3(1, 0, 0));
    send0(v3(0, 1, 0));
    send0(v3(0, 0, 1));
    wait_out0();
    expect0("post_rst0", e3(1, 2, 3));
    expect0("post_rst1", e3(4, 5, 6));
    expect0("post_rst2", e3(7, 8, 9));
    chk("post_rst_end", bus0.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
